// File: rtl/riscv_mc_control_pkg.sv
// riscv_mc_control_pkg: shared types and encodings for the multi-cycle RV32I control unit.
// Contents: ALU operation classes, FSM states, trap causes, opcode classes,
// RV32I base opcodes, PcSel and MemToReg encodings.
package riscv_mc_control_pkg;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'd0,
        ALU_RTYPE  = 2'd1,
        ALU_ITYPE  = 2'd2,
        ALU_BRANCH = 2'd3
    } aluop_t;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } mc_state_t;

    typedef enum logic [1:0] {
        TRAP_NONE    = 2'd0,
        TRAP_ILLEGAL = 2'd1,
        TRAP_SYSTEM  = 2'd2,
        TRAP_TIMEOUT = 2'd3
    } trap_cause_t;

    typedef enum logic [3:0] {
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC,
        CLS_SYSTEM,
        CLS_ILLEGAL
    } opc_class_t;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] PCSEL_PLUS4  = 2'd0;
    localparam logic [1:0] PCSEL_BRANCH = 2'd1;
    localparam logic [1:0] PCSEL_JALR   = 2'd2;

    localparam logic [2:0] M2R_ALU = 3'd0;
    localparam logic [2:0] M2R_MEM = 3'd1;
    localparam logic [2:0] M2R_PC4 = 3'd2;
    localparam logic [2:0] M2R_IMM = 3'd3;

endpackage

// File: rtl/riscv_mc_control_opc_decode.sv
// mc_opc_decode: combinational opcode-to-class and legality decoder.
// Ports: opc_i (7-bit opcode) -> cls_o (instruction class), legal_o (opcode is one of the supported RV32I base opcodes).
module mc_opc_decode
    import riscv_mc_control_pkg::*;
(
    input  logic [6:0] opc_i,
    output opc_class_t cls_o,
    output logic       legal_o
);

    always_comb begin
        cls_o = CLS_ILLEGAL;
        case (opc_i)
            OPC_RTYPE:  cls_o = CLS_R;
            OPC_ITYPE:  cls_o = CLS_I;
            OPC_LOAD:   cls_o = CLS_LOAD;
            OPC_STORE:  cls_o = CLS_STORE;
            OPC_BRANCH: cls_o = CLS_BRANCH;
            OPC_JAL:    cls_o = CLS_JAL;
            OPC_JALR:   cls_o = CLS_JALR;
            OPC_LUI:    cls_o = CLS_LUI;
            OPC_AUIPC:  cls_o = CLS_AUIPC;
            OPC_SYSTEM: cls_o = CLS_SYSTEM;
            default:    cls_o = CLS_ILLEGAL;
        endcase
    end

    assign legal_o = (cls_o != CLS_ILLEGAL);

endmodule

// File: rtl/riscv_mc_control.sv
// riscv_mc_control: multi-cycle RV32I control FSM (fetch/decode/exec/mem/wb/halt).
// Inputs : clk, reset (sync, active-high), inst_opc, take_branch, imem_ready, dmem_ready.
// Outputs: imem_req, CTL_* datapath strobes/selects, halted, trap_cause, instret.
// Optional: define RISCV_BUS_TIMEOUT_EN to halt with cause 3 after TIMEOUT_CYCLES
// consecutive bus wait cycles; otherwise bus waits are unbounded.
module riscv_mc_control
    import riscv_mc_control_pkg::*;
#(
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           inst_opc,
    input  logic                 take_branch,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 imem_req,
    output logic                 CTL_IrWrite,
    output logic                 CTL_PcWrite,
    output logic [1:0]           CTL_PcSel,
    output logic                 CTL_AluSrcA,
    output logic                 CTL_AluSrc,
    output aluop_t               CTL_AluOp,
    output logic                 CTL_MemRead,
    output logic                 CTL_MemWrite,
    output logic [2:0]           CTL_MemToReg,
    output logic                 CTL_RegWrite,
    output logic                 halted,
    output logic [1:0]           trap_cause,
    output logic [CNT_WIDTH-1:0] instret
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    mc_state_t             state_q, state_d;
    logic [1:0]            cause_q, cause_d;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  retire;
    logic                  tmo;
    opc_class_t            cls;
    logic                  legal;

    mc_opc_decode u_dec (
        .opc_i   (inst_opc),
        .cls_o   (cls),
        .legal_o (legal)
    );

`ifdef RISCV_BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_q;
    logic          pend;
    // A pending cycle is one with a request up and no ready; the counter is
    // zero whenever a request is granted or not outstanding, so it restarts on
    // every entry to FETCH or MEM.
    assign pend = (state_q == ST_FETCH && !imem_ready) || (state_q == ST_MEM && !dmem_ready);
    assign tmo  = pend && (wait_q == TW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk) begin
        wait_q <= (reset || !pend) ? '0 : wait_q + 1'b1;
    end
`else
    assign tmo = 1'b0;
`endif

    // Outputs decode the registered state; everything is forced low while
    // reset is sampled so a request never leaks into a reset cycle.
    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        retire       = 1'b0;
        imem_req     = 1'b0;
        CTL_IrWrite  = 1'b0;
        CTL_PcWrite  = 1'b0;
        CTL_PcSel    = PCSEL_PLUS4;
        CTL_AluSrcA  = 1'b0;
        CTL_AluSrc   = 1'b0;
        CTL_AluOp    = ALU_ADD;
        CTL_MemRead  = 1'b0;
        CTL_MemWrite = 1'b0;
        CTL_MemToReg = M2R_ALU;
        CTL_RegWrite = 1'b0;
        halted       = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        CTL_IrWrite = 1'b1;
                        CTL_PcWrite = 1'b1;
                        state_d     = ST_DECODE;
                    end else if (tmo) begin
                        state_d = ST_HALT;
                        cause_d = TRAP_TIMEOUT;
                    end
                end
                ST_DECODE: begin
                    state_d = (cls == CLS_SYSTEM || !legal) ? ST_HALT : ST_EXEC;
                    cause_d = (cls == CLS_SYSTEM) ? TRAP_SYSTEM : !legal ? TRAP_ILLEGAL : cause_q;
                end
                ST_EXEC: begin
                    state_d = ST_WB;
                    case (cls)
                        CLS_R: CTL_AluOp = ALU_RTYPE;
                        CLS_I: begin
                            CTL_AluSrc = 1'b1;
                            CTL_AluOp  = ALU_ITYPE;
                        end
                        CLS_LOAD, CLS_STORE: begin
                            CTL_AluSrc = 1'b1;
                            state_d    = ST_MEM;
                        end
                        CLS_BRANCH: begin
                            CTL_AluOp   = ALU_BRANCH;
                            CTL_PcWrite = take_branch;
                            CTL_PcSel   = PCSEL_BRANCH;
                            state_d     = ST_FETCH;
                            retire      = 1'b1;
                        end
                        CLS_JAL: begin
                            CTL_PcSel   = PCSEL_BRANCH;
                            CTL_PcWrite = 1'b1;
                        end
                        CLS_JALR: begin
                            CTL_PcSel   = PCSEL_JALR;
                            CTL_PcWrite = 1'b1;
                        end
                        CLS_AUIPC: begin
                            CTL_AluSrcA = 1'b1;
                            CTL_AluSrc  = 1'b1;
                        end
                        CLS_LUI: state_d = ST_WB;
                        default: begin
                            // Opcode changed under a decoded instruction.
                            state_d = ST_HALT;
                            cause_d = TRAP_ILLEGAL;
                        end
                    endcase
                end
                ST_MEM: begin
                    CTL_MemRead  = (cls == CLS_LOAD);
                    CTL_MemWrite = (cls != CLS_LOAD);
                    if (dmem_ready) begin
                        state_d = (cls == CLS_LOAD) ? ST_WB : ST_FETCH;
                        retire  = (cls != CLS_LOAD);
                    end else if (tmo) begin
                        state_d = ST_HALT;
                        cause_d = TRAP_TIMEOUT;
                    end
                end
                ST_WB: begin
                    CTL_RegWrite = 1'b1;
                    CTL_MemToReg = (cls == CLS_LOAD) ? M2R_MEM :
                                   (cls == CLS_JAL || cls == CLS_JALR) ? M2R_PC4 :
                                   (cls == CLS_LUI) ? M2R_IMM : M2R_ALU;
                    state_d      = ST_FETCH;
                    retire       = 1'b1;
                end
                ST_HALT: halted = 1'b1;
                default: state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            cause_q <= TRAP_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_q + CNT_WIDTH'(retire);
        end
    end

    assign trap_cause = reset ? 2'd0 : cause_q;
    assign instret    = reset ? '0 : cnt_q;

endmodule
